// File: rtl/uart_prog_pkg.sv
// Shared definitions for the UART program streamer: FSM states, frame
// length and parity helpers.
package uart_prog_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP,
    ST_END
  } state_t;

  // Bit periods in one frame, excluding any inter-frame gap.
  function automatic int frame_bits(input int data_bits, input int parity_en,
                                    input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

  // Even parity when odd=0, odd parity when odd=1. Data must already be masked.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: a down-counter that pulses tick on the last cycle of every
// CLKS_PER_BIT-cycle period. restart starts a fresh period on the next cycle.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic clock,
  input  logic resetb,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == '0) && !restart;

  // Reload on restart or at the end of a period, otherwise count down.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_reg <= LAST;
    end else if (restart || cnt_reg == '0) begin
      cnt_reg <= LAST;
    end else begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/uart_prog_streamer.sv
// UART program loader: on a rising mprj_ready edge, fetches len bytes from a
// 1-cycle-latency ROM and sends each as a UART frame on tx_o.
module uart_prog_streamer
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0,
  parameter int START_DLY    = 1000,
  parameter int ADDR_W       = 14
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              ready_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              abort_i,
  output logic              rom_rd_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [ADDR_W:0]   byte_cnt_o
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam int BCW        = $clog2(FRAME_BITS + GAP_BITS + 1);
  localparam int DLY        = (START_DLY < 1) ? 1 : START_DLY;
  localparam int WCW        = (DLY > 1) ? $clog2(DLY) : 1;
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  state_t              state_reg, state_next;
  logic                ready_s1_reg, ready_s2_reg, ready_d_reg;
  logic [ADDR_W:0]     len_reg, byte_cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [WCW-1:0]      wait_cnt_reg;
  logic [BCW-1:0]      bit_cnt_reg;
  logic [7:0]          shift_reg;
  logic                parity_reg, tx_reg, busy_reg, done_reg, aborted_reg;
  logic                abort_lat_reg;
  logic                arm, tick, restart, frame_end, last_byte, abort_req, tx_next;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clock   (clock),
    .resetb  (resetb),
    .restart (restart),
    .tick    (tick)
  );

  assign arm        = ready_s2_reg && !ready_d_reg;
  assign last_byte  = (byte_cnt_reg + (ADDR_W + 1)'(1)) == len_reg;
  assign abort_req  = abort_lat_reg || abort_i;
  assign rom_rd_o   = (state_reg == ST_FETCH);
  assign rom_addr_o = addr_reg;
  assign tx_o       = tx_reg;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign aborted_o  = aborted_reg;
  assign byte_cnt_o = byte_cnt_reg;

  // Ready synchroniser plus edge detector; flops reset high so a ready that
  // is already high when reset lifts does not count as a rising edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ready_s1_reg <= 1'b1;
      ready_s2_reg <= 1'b1;
      ready_d_reg  <= 1'b1;
    end else begin
      ready_s1_reg <= ready_i;
      ready_s2_reg <= ready_s1_reg;
      ready_d_reg  <= ready_s2_reg;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state, bit-timer restart, frame-end strobe and serial line value.
  always_comb begin
    state_next = state_reg;
    restart    = 1'b0;
    frame_end  = 1'b0;
    tx_next    = 1'b1;
    case (state_reg)
      ST_IDLE:  if (arm && len_i != '0) state_next = ST_WAIT;
      ST_WAIT: begin
        if (abort_req)                           state_next = ST_IDLE;
        else if (wait_cnt_reg == WCW'(DLY - 1))  state_next = ST_FETCH;
      end
      ST_FETCH: state_next = ST_LOAD;
      ST_LOAD: begin
        restart    = 1'b1;
        state_next = ST_START;
      end
      ST_START: begin
        tx_next = 1'b0;
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        tx_next = shift_reg[0];
        if (tick && bit_cnt_reg == BCW'(DATA_BITS))
          state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx_next = parity_reg;
        if (tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (tick && bit_cnt_reg == BCW'(FRAME_BITS - 1)) begin
          if (GAP_BITS == 0) frame_end  = 1'b1;
          else               state_next = ST_GAP;
        end
      end
      ST_GAP:   if (tick && bit_cnt_reg == BCW'(FRAME_BITS + GAP_BITS - 1)) frame_end = 1'b1;
      ST_END:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (frame_end) begin
      if (last_byte)      state_next = ST_END;
      else if (abort_req) state_next = ST_IDLE;
      else                state_next = ST_FETCH;
    end
  end

  // Abort latch: remembered while a transfer is in progress, cleared once idle.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)                                          abort_lat_reg <= 1'b0;
    else if (state_reg == ST_IDLE || state_reg == ST_END) abort_lat_reg <= 1'b0;
    else if (abort_i)                                     abort_lat_reg <= 1'b1;
  end

  // Datapath: line register, counters, shift register and status flags.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_reg       <= 1'b1;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      addr_reg     <= '0;
      wait_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
    end else begin
      tx_reg <= tx_next;
      case (state_reg)
        ST_IDLE: begin
          if (arm) begin
            // Every arming reloads the program from address 0.
            len_reg      <= len_i;
            byte_cnt_reg <= '0;
            addr_reg     <= '0;
            wait_cnt_reg <= '0;
            aborted_reg  <= 1'b0;
            done_reg     <= (len_i == '0);
            busy_reg     <= (len_i != '0);
          end
        end
        ST_WAIT: begin
          if (abort_req) begin
            aborted_reg <= 1'b1;
            busy_reg    <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_LOAD: begin
          shift_reg   <= rom_data_i & DATA_MASK;
          parity_reg  <= parity_bit(rom_data_i & DATA_MASK, 1'(PARITY_ODD));
          bit_cnt_reg <= '0;
        end
        ST_START, ST_PARITY, ST_STOP, ST_GAP: begin
          if (tick) bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
        ST_DATA: begin
          if (tick) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            shift_reg   <= shift_reg >> 1;
          end
        end
        ST_END: begin
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end
        default: ;
      endcase
      if (frame_end) begin
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
        addr_reg     <= addr_reg + 1'b1;
        if (!last_byte && abort_req) begin
          aborted_reg <= 1'b1;
          busy_reg    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_streamer.sv
// Directed bench for uart_prog_streamer: 8N1 instance for the main flows and
// an 8E2 instance for the parity / two-stop-bit frame.
module tb_uart_prog_streamer;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          resetb;
  logic          ready_a, abort_a, ready_p, abort_p;
  logic [AW:0]   len_a, len_p;
  logic          rd_a, rd_p;
  logic [AW-1:0] addr_a, addr_p;
  logic [7:0]    data_a, data_p;
  logic          tx_a, busy_a, done_a, aborted_a;
  logic          tx_p, busy_p, done_p, aborted_p;
  logic [AW:0]   cnt_a, cnt_p;
  logic [7:0]    rom_a [0:15];
  logic [7:0]    rom_p [0:15];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ROM models with one cycle of read latency.
  always @(posedge clock) if (rd_a) data_a <= rom_a[addr_a];
  always @(posedge clock) if (rd_p) data_p <= rom_p[addr_p];

  uart_prog_streamer #(
    .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
    .STOP_BITS(1), .GAP_BITS(0), .START_DLY(8), .ADDR_W(AW)
  ) dut_a (
    .clock(clock), .resetb(resetb), .ready_i(ready_a), .len_i(len_a),
    .abort_i(abort_a), .rom_rd_o(rd_a), .rom_addr_o(addr_a), .rom_data_i(data_a),
    .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a), .aborted_o(aborted_a),
    .byte_cnt_o(cnt_a)
  );

  uart_prog_streamer #(
    .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
    .STOP_BITS(2), .GAP_BITS(0), .START_DLY(8), .ADDR_W(AW)
  ) dut_p (
    .clock(clock), .resetb(resetb), .ready_i(ready_p), .len_i(len_p),
    .abort_i(abort_p), .rom_rd_o(rd_p), .rom_addr_o(addr_p), .rom_data_i(data_p),
    .tx_o(tx_p), .busy_o(busy_p), .done_o(done_p), .aborted_o(aborted_p),
    .byte_cnt_o(cnt_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a start bit, then sample every cycle of nbits periods.
  task automatic capture(input bit sel, input int nbits, output logic [15:0] bits,
                         output bit stable, output int t0, output bit found);
    logic s, first;
    bits = '0; stable = 1'b1; t0 = 0; found = 1'b0; first = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      s = sel ? tx_p : tx_a;
      if (s === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      t0 = cyc;
      for (int c = 0; c < nbits * 4; c++) begin
        if (c > 0) @(negedge clock);
        s = sel ? tx_p : tx_a;
        if (c % 4 == 0) first = s;
        else if (s !== first) stable = 1'b0;
        if (c % 4 == 2) bits[c / 4] = s;
      end
    end
  endtask

  task automatic rx_frame(input bit sel, input int nbits, input logic [15:0] exp,
                          input string tag, output int t0);
    logic [15:0] bits;
    bit stable, found;
    capture(sel, nbits, bits, stable, t0, found);
    chk({tag, "_found"}, 32'(found), 32'd1);
    chk({tag, "_bits"}, 32'(bits), 32'(exp));
    chk({tag, "_bitlen"}, 32'(stable), 32'd1);
    $display("frame %s: bits=%03h start_cycle=%0d", tag, bits, t0);
  endtask

  initial begin
    int t1, t2, t3, lows;
    resetb = 1'b0; ready_a = 1'b1; ready_p = 1'b0;
    abort_a = 1'b0; abort_p = 1'b0; len_a = 5'd3; len_p = 5'd1;
    data_a = 8'h00; data_p = 8'h00;
    for (int i = 0; i < 16; i++) begin rom_a[i] = 8'h00; rom_p[i] = 8'h00; end

    // 1: reset values, and ready held high through reset does not arm
    repeat (5) @(negedge clock);
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_rd", 32'(rd_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    resetb = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clock); if (tx_a !== 1'b1) lows++; end
    chk("noarm_busy", 32'(busy_a), 32'd0);
    chk("noarm_done", 32'(done_a), 32'd0);
    chk("noarm_tx", 32'(lows), 32'd0);
    ready_a = 1'b0;
    repeat (4) @(negedge clock);

    // 2: three 8N1 frames, 42-cycle start spacing (40-cycle frame + 2 idle)
    rom_a[0] = 8'h55; rom_a[1] = 8'hA3; rom_a[2] = 8'h0F;
    len_a = 5'd3; ready_a = 1'b1;
    rx_frame(1'b0, 10, 16'h2AA, "f55", t1);
    rx_frame(1'b0, 10, 16'h346, "fA3", t2);
    rx_frame(1'b0, 10, 16'h21E, "f0F", t3);
    chk("gap12", 32'(t2 - t1), 32'd42);
    chk("gap23", 32'(t3 - t2), 32'd42);
    for (int i = 0; i < 20 && done_a !== 1'b1; i++) @(negedge clock);
    chk("run_done", 32'(done_a), 32'd1);
    chk("run_cnt", 32'(cnt_a), 32'd3);
    chk("run_busy", 32'(busy_a), 32'd0);
    chk("run_aborted", 32'(aborted_a), 32'd0);

    // 3: 8E2 frame of 0x07: parity 1, 12 bits = 48 cycles
    rom_p[0] = 8'h07; len_p = 5'd1; ready_p = 1'b1;
    rx_frame(1'b1, 12, 16'hE0E, "p07", t1);
    @(negedge clock);
    chk("p_after_frame_tx", 32'(tx_p), 32'd1);
    for (int i = 0; i < 20 && done_p !== 1'b1; i++) @(negedge clock);
    chk("p_done", 32'(done_p), 32'd1);
    chk("p_cnt", 32'(cnt_p), 32'd1);

    // 4: len=4, abort pulsed mid second frame; second frame still completes
    ready_a = 1'b0;
    repeat (4) @(negedge clock);
    rom_a[0] = 8'h11; rom_a[1] = 8'h22; rom_a[2] = 8'h33; rom_a[3] = 8'h44;
    len_a = 5'd4; ready_a = 1'b1;
    rx_frame(1'b0, 10, 16'h222, "a11", t1);
    fork
      rx_frame(1'b0, 10, 16'h244, "a22", t2);
      begin
        repeat (15) @(negedge clock);
        abort_a = 1'b1;
        @(negedge clock);
        abort_a = 1'b0;
      end
    join
    for (int i = 0; i < 20 && aborted_a !== 1'b1; i++) @(negedge clock);
    chk("ab_aborted", 32'(aborted_a), 32'd1);
    chk("ab_done", 32'(done_a), 32'd0);
    chk("ab_cnt", 32'(cnt_a), 32'd2);
    chk("ab_busy", 32'(busy_a), 32'd0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clock); if (tx_a !== 1'b1) lows++; end
    chk("ab_no_third", 32'(lows), 32'd0);

    // 5: len=0 -> done within 4 cycles, line never leaves idle
    ready_a = 1'b0;
    repeat (4) @(negedge clock);
    len_a = 5'd0; ready_a = 1'b1;
    lows = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clock); if (tx_a !== 1'b1) lows++; end
    chk("z_done", 32'(done_a), 32'd1);
    chk("z_busy", 32'(busy_a), 32'd0);
    chk("z_aborted", 32'(aborted_a), 32'd0);
    for (int i = 0; i < 30; i++) begin @(negedge clock); if (tx_a !== 1'b1) lows++; end
    chk("z_tx_idle", 32'(lows), 32'd0);

    // 6: reset mid-DATA forces the line high at once; re-arm restarts at addr 0
    ready_a = 1'b0;
    repeat (4) @(negedge clock);
    rom_a[0] = 8'h55; rom_a[1] = 8'hA3; rom_a[2] = 8'h0F;
    len_a = 5'd3; ready_a = 1'b1;
    for (int i = 0; i < 300 && tx_a !== 1'b0; i++) @(negedge clock);
    repeat (9) @(negedge clock);
    chk("mid_tx_low", 32'(tx_a), 32'd0);
    #2 resetb = 1'b0;
    #1;
    chk("async_tx", 32'(tx_a), 32'd1);
    chk("async_busy", 32'(busy_a), 32'd0);
    chk("async_cnt", 32'(cnt_a), 32'd0);
    ready_a = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    repeat (4) @(negedge clock);
    ready_a = 1'b1;
    rx_frame(1'b0, 10, 16'h2AA, "r55", t1);
    for (int i = 0; i < 200 && done_a !== 1'b1; i++) @(negedge clock);
    chk("r_done", 32'(done_a), 32'd1);
    chk("r_cnt", 32'(cnt_a), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
